// File: rtl/rv32i_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control unit:
// opcodes, one-hot stage encodings and ALU control codes.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One-hot stages; HALT is the all-zero code used only when halting on illegal opcodes
  typedef enum logic [4:0] {
    ST_HALT      = 5'b00000,
    ST_FETCH     = 5'b00001,
    ST_DECODE    = 5'b00010,
    ST_EXECUTE   = 5'b00100,
    ST_MEMORY    = 5'b01000,
    ST_WRITEBACK = 5'b10000
  } stage_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
  localparam logic [3:0] ALU_BLT  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_BLTU = 4'b1100;
  localparam logic [3:0] ALU_BGEU = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b1110;
  localparam logic [3:0] ALU_AND  = 4'b1111;

endpackage

// File: rtl/rv32i_alu_ctrl_dec.sv
// Combinational instruction field decoder: {opcode, funct3, funct7[5]}
// -> ALU control code, PC source select and legality flag.
module rv32i_alu_ctrl_dec
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       pc_src,
  output logic       legal
);

  // Decode operation class and ALU code; anything unlisted is illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    pc_src   = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_R, OP_IALU: begin
        case (funct3)
          3'b000:  alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE: alu_ctrl = ALU_ADD;
      OP_JAL, OP_JALR: begin
        alu_ctrl = ALU_ADD;
        pc_src   = 1'b1;
      end
      OP_BRANCH: begin
        pc_src = 1'b1;
        case (funct3)
          3'b000:  alu_ctrl = ALU_BEQ;
          3'b001:  alu_ctrl = ALU_BNE;
          3'b100:  alu_ctrl = ALU_BLT;
          3'b101:  alu_ctrl = ALU_BGE;
          3'b110:  alu_ctrl = ALU_BLTU;
          3'b111:  alu_ctrl = ALU_BGEU;
          default: legal    = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencing with memory-ready stalls and a retired-instruction counter.
// Optional macro ILLEGAL_HALT_EN: an illegal opcode parks the unit in HALT
// (stage 00000) until reset; otherwise the instruction is skipped.
//
// state     | meaning
// HALT      | stopped after an illegal opcode (ILLEGAL_HALT_EN only)
// FETCH     | memory read of next instruction, wait for mem_ready
// DECODE    | legality check on the fetched instruction
// EXECUTE   | ALU operation, branch/jump PC update
// MEMORY    | load/store access, wait for mem_ready
// WRITEBACK | register file write, retire
module rv32i_ctrl_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 Cond_Chk_reg,
  output logic [4:0]           current_stage,
  output logic [6:0]           opcode_reg,
  output logic [3:0]           AluControl_reg,
  output logic                 PCSrc_reg,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  stage_e     stage;
  logic [6:0] ir_op;
  logic [2:0] ir_f3;
  logic       ir_f7_5;
  logic [3:0] dec_alu;
  logic       dec_pc_src;
  logic       dec_legal;

  // Only opcode, funct3 and funct7[5] steer control; operand fields belong to the datapath
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign current_stage = stage;

  rv32i_alu_ctrl_dec u_dec (
    .opcode   (ir_op),
    .funct3   (ir_f3),
    .funct7_5 (ir_f7_5),
    .alu_ctrl (dec_alu),
    .pc_src   (dec_pc_src),
    .legal    (dec_legal)
  );

  // Stage sequencing, field latching and retire counting
  always_ff @(posedge clk) begin
    if (reset) begin
      stage          <= ST_FETCH;
      ir_op          <= '0;
      ir_f3          <= '0;
      ir_f7_5        <= 1'b0;
      opcode_reg     <= '0;
      AluControl_reg <= '0;
      PCSrc_reg      <= 1'b0;
      instret        <= '0;
    end else begin
      case (stage)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_op   <= instr[6:0];
            ir_f3   <= instr[14:12];
            ir_f7_5 <= instr[30];
            stage   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            opcode_reg     <= ir_op;
            AluControl_reg <= dec_alu;
            PCSrc_reg      <= dec_pc_src;
            stage          <= ST_EXECUTE;
          end else begin
`ifdef ILLEGAL_HALT_EN
            stage <= ST_HALT;
`else
            stage <= ST_FETCH;
`endif
          end
        end
        ST_EXECUTE: begin
          case (opcode_reg)
            OP_LOAD, OP_STORE: stage <= ST_MEMORY;
            OP_BRANCH: begin
              stage   <= ST_FETCH;
              instret <= instret + ONE;
            end
            default: stage <= ST_WRITEBACK;
          endcase
        end
        ST_MEMORY: begin
          if (mem_ready) begin
            if (opcode_reg == OP_STORE) begin
              stage   <= ST_FETCH;
              instret <= instret + ONE;
            end else begin
              stage <= ST_WRITEBACK;
            end
          end
        end
        ST_WRITEBACK: begin
          stage   <= ST_FETCH;
          instret <= instret + ONE;
        end
        default: begin
`ifdef ILLEGAL_HALT_EN
          stage <= ST_HALT;
`else
          stage <= ST_FETCH;
`endif
        end
      endcase
    end
  end

  // Strobe decode from stage and latched fields; suppressed while reset is asserted
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (stage)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_DECODE: illegal = !dec_legal;
        ST_EXECUTE: begin
          if (opcode_reg == OP_BRANCH)
            pc_write = Cond_Chk_reg;
          else if (opcode_reg == OP_JAL || opcode_reg == OP_JALR)
            pc_write = 1'b1;
        end
        ST_MEMORY: begin
          mem_req = 1'b1;
          mem_we  = (opcode_reg == OP_STORE);
        end
        ST_WRITEBACK: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Self-checking bench for rv32i_ctrl_fsm: directed vector table, hand
// sequences for reset abort and counter wrap, and randomized instructions
// checked against a stage-path reference model.
module tb_rv32i_ctrl_fsm;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  // instruction classes of the reference model
  localparam int C_WB = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_ILL = 5;

  typedef struct {
    logic [31:0] instr;
    logic        cond;
    int          fwait;
    int          mwait;
    int          cls;
    int          alu;
    int          pcs;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          mem_ready;
  logic          cond_chk;
  logic [4:0]    current_stage;
  logic [6:0]    opcode_reg;
  logic [3:0]    alu_control;
  logic          pc_src;
  logic          ir_write, pc_write, mem_req, mem_we, reg_write, illegal;
  logic [W-1:0]  instret;

  int tests = 0;
  int fails = 0;
  int exp_instret = 0;
  int exp_op = 0, exp_alu = 0, exp_pcs = 0;
  vec_t vecs[24];

  rv32i_ctrl_fsm #(.INSTRET_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr          (instr),
    .mem_ready      (mem_ready),
    .Cond_Chk_reg   (cond_chk),
    .current_stage  (current_stage),
    .opcode_reg     (opcode_reg),
    .AluControl_reg (alu_control),
    .PCSrc_reg      (pc_src),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .reg_write      (reg_write),
    .illegal        (illegal),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int stg, input int mreq, input int mwe,
                         input int irw, input int pcw, input int rw, input int ill);
    chk({tag, ".stage"},     32'(current_stage), 32'(stg));
    chk({tag, ".mem_req"},   32'(mem_req),       32'(mreq));
    chk({tag, ".mem_we"},    32'(mem_we),        32'(mwe));
    chk({tag, ".ir_write"},  32'(ir_write),      32'(irw));
    chk({tag, ".pc_write"},  32'(pc_write),      32'(pcw));
    chk({tag, ".reg_write"}, 32'(reg_write),     32'(rw));
    chk({tag, ".illegal"},   32'(illegal),       32'(ill));
    chk({tag, ".opcode"},    32'(opcode_reg),    32'(exp_op));
    chk({tag, ".alu"},       32'(alu_control),   32'(exp_alu));
    chk({tag, ".pcsrc"},     32'(pc_src),        32'(exp_pcs));
    chk({tag, ".instret"},   32'(instret),       32'(exp_instret & MASK));
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0; instr = '0; cond_chk = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_instret = 0; exp_op = 0; exp_alu = 0; exp_pcs = 0;
  endtask

  // Reference classification from the instruction set definition
  function automatic void model(input logic [31:0] i, output int cls, output int alu, output int pcs);
    int alu_by_f3[8] = '{0, 2, 3, 4, 5, 6, 14, 15};
    int f3 = int'(i[14:12]);
    cls = C_ILL; alu = 0; pcs = 0;
    case (i[6:0])
      7'b0110011: begin
        cls = C_WB; alu = alu_by_f3[f3];
        if (i[30] && f3 == 0) alu = 1;
        if (i[30] && f3 == 5) alu = 7;
      end
      7'b0010011: begin
        cls = C_WB; alu = alu_by_f3[f3];
        if (i[30] && f3 == 5) alu = 7;
      end
      7'b0110111, 7'b0010111: cls = C_WB;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1101111, 7'b1100111: begin cls = C_JMP; pcs = 1; end
      7'b1100011: if (f3 != 2 && f3 != 3) begin
        cls = C_BR; pcs = 1; alu = 8 + ((f3 >= 4) ? f3 - 2 : f3);
      end
      default: ;
    endcase
  endfunction

  // Walk one instruction through its expected stage path, checking every cycle
  task automatic run_instr(input vec_t v);
    instr = v.instr;
    for (int w = 0; w <= v.fwait; w++) begin
      mem_ready = (w == v.fwait);
      cond_chk  = 1'($urandom);
      #1;
      chk_all("fetch", 1, 1, 0, int'(mem_ready), int'(mem_ready), 0, 0);
      tick();
    end
    instr = $urandom;
    mem_ready = 1'($urandom);
    #1;
    chk_all("decode", 2, 0, 0, 0, 0, 0, (v.cls == C_ILL) ? 1 : 0);
    tick();
    if (v.cls == C_ILL) begin
`ifdef ILLEGAL_HALT_EN
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'($urandom);
        #1;
        chk_all("halt", 0, 0, 0, 0, 0, 0, 0);
        tick();
      end
      do_reset();
`endif
      return;
    end
    exp_op = int'(v.instr[6:0]); exp_alu = v.alu; exp_pcs = v.pcs;
    cond_chk  = v.cond;
    mem_ready = 1'($urandom);
    #1;
    chk_all("execute", 4, 0, 0, 0,
            (v.cls == C_BR) ? int'(v.cond) : ((v.cls == C_JMP) ? 1 : 0), 0, 0);
    tick();
    if (v.cls == C_BR) begin
      exp_instret++;
      return;
    end
    if (v.cls == C_LOAD || v.cls == C_STORE) begin
      for (int w = 0; w <= v.mwait; w++) begin
        mem_ready = (w == v.mwait);
        #1;
        chk_all("memory", 8, 1, (v.cls == C_STORE) ? 1 : 0, 0, 0, 0, 0);
        tick();
      end
      if (v.cls == C_STORE) begin
        exp_instret++;
        return;
      end
    end
    mem_ready = 1'($urandom);
    #1;
    chk_all("writeback", 16, 0, 0, 0, 0, 1, 0);
    tick();
    exp_instret++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int f3s[6] = '{0, 1, 4, 5, 6, 7};
    int k = $urandom_range(10, 0);
    case (k)
      0: begin
        r[6:0] = 7'b0110011;
        r[31:25] = 7'b0;
        if (r[14:12] == 3'd0 || r[14:12] == 3'd5) r[30] = 1'($urandom);
      end
      1: begin
        r[6:0] = 7'b0010011;
        if (r[14:12] == 3'd1) r[31:25] = 7'b0;
        if (r[14:12] == 3'd5) begin r[31:25] = 7'b0; r[30] = 1'($urandom); end
      end
      2: r[6:0] = 7'b0110111;
      3: r[6:0] = 7'b0010111;
      4: r[6:0] = 7'b0000011;
      5: r[6:0] = 7'b0100011;
      6, 7: begin r[6:0] = 7'b1100011; r[14:12] = 3'(f3s[$urandom_range(5, 0)]); end
      8: r[6:0] = 7'b1101111;
      9: begin r[6:0] = 7'b1100111; r[14:12] = 3'b000; end
      default: begin
        if (r[0]) r[6:0] = 7'b1111111;
        else begin r[6:0] = 7'b1100011; r[14:12] = {2'b01, 1'($urandom)}; end
      end
    endcase
    return r;
  endfunction

  initial begin
    vec_t v;
    vecs[0]  = '{32'h002081B3, 1'b0, 0, 0, C_WB,    0,  0};
    vecs[1]  = '{32'h402081B3, 1'b0, 1, 0, C_WB,    1,  0};
    vecs[2]  = '{32'h00108463, 1'b1, 0, 0, C_BR,    8,  1};
    vecs[3]  = '{32'h00108463, 1'b0, 0, 0, C_BR,    8,  1};
    vecs[4]  = '{32'h0040A283, 1'b0, 0, 3, C_LOAD,  0,  0};
    vecs[5]  = '{32'h0050A223, 1'b0, 2, 1, C_STORE, 0,  0};
    vecs[6]  = '{32'h008000EF, 1'b0, 0, 0, C_JMP,   0,  1};
    vecs[7]  = '{32'h000080E7, 1'b0, 0, 0, C_JMP,   0,  1};
    vecs[8]  = '{32'h123452B7, 1'b0, 0, 0, C_WB,    0,  0};
    vecs[9]  = '{32'h00001297, 1'b0, 0, 0, C_WB,    0,  0};
    vecs[10] = '{32'h002091B3, 1'b0, 0, 0, C_WB,    2,  0};
    vecs[11] = '{32'h4020D1B3, 1'b0, 0, 0, C_WB,    7,  0};
    vecs[12] = '{32'h0020D1B3, 1'b0, 0, 0, C_WB,    6,  0};
    vecs[13] = '{32'h0FF0F293, 1'b0, 0, 0, C_WB,    15, 0};
    vecs[14] = '{32'h0050A293, 1'b0, 0, 0, C_WB,    3,  0};
    vecs[15] = '{32'h0020E463, 1'b1, 0, 0, C_BR,    12, 1};
    vecs[16] = '{32'h0020F463, 1'b0, 0, 0, C_BR,    13, 1};
    vecs[17] = '{32'h00209463, 1'b1, 0, 0, C_BR,    9,  1};
    vecs[18] = '{32'h0020C1B3, 1'b0, 0, 0, C_WB,    5,  0};
    vecs[19] = '{32'h0020E1B3, 1'b0, 0, 0, C_WB,    14, 0};
    vecs[20] = '{32'h0020B1B3, 1'b0, 0, 0, C_WB,    4,  0};
    vecs[21] = '{32'hFFFFFFFF, 1'b0, 0, 0, C_ILL,   0,  0};
    vecs[22] = '{32'h002081B3, 1'b0, 0, 0, C_WB,    0,  0};
    vecs[23] = '{32'h0020A463, 1'b0, 0, 0, C_ILL,   0,  0};

    reset = 1'b1; instr = '0; mem_ready = 1'b0; cond_chk = 1'b0;
    #1;
    do_reset();
    #1;
    chk_all("reset", 1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) run_instr(vecs[i]);

    // Reset while a load waits in MEMORY aborts it without strobes or retire
    run_instr(vecs[0]);
    instr = 32'h0040A283; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    chk("abort.stage_mem", 32'(current_stage), 32'd8);
    reset = 1'b1;
    #1;
    chk("abort.reg_write", 32'(reg_write), 32'd0);
    chk("abort.mem_req",   32'(mem_req),   32'd0);
    tick();
    reset = 1'b0;
    exp_instret = 0; exp_op = 0; exp_alu = 0; exp_pcs = 0;
    #1;
    chk_all("abort", 1, 1, 0, 0, 0, 0, 0);

    // Counter wraps from all-ones back to zero
    for (int i = 0; i < MASK; i++) run_instr(vecs[0]);
    mem_ready = 1'b0;
    #1;
    chk("wrap.all_ones", 32'(instret), 32'(MASK));
    run_instr(vecs[6]);
    mem_ready = 1'b0;
    #1;
    chk("wrap.zero", 32'(instret), 32'd0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 200; n++) begin
      v.instr = rand_instr();
      v.cond  = 1'($urandom);
      v.fwait = $urandom_range(2, 0);
      v.mwait = $urandom_range(3, 0);
      model(v.instr, v.cls, v.alu, v.pcs);
      run_instr(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_fsm.md
Name: rv32i_ctrl_fsm

Overview:
Multicycle control unit for the RV32I core; the producer side of the ALU control interface. It drives opcode_reg, AluControl_reg, PCSrc_reg and current_stage to the ALU and consumes the ALU's Cond_Chk_reg. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction, stalls on a memory ready handshake, and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr  in  32  memory read data, sampled as instruction in FETCH
mem_ready  in  1  memory handshake: access completes in the cycle it is high
Cond_Chk_reg  in  1  branch condition from ALU, sampled in EXECUTE
current_stage  out  5  one-hot stage: FETCH=00001 DECODE=00010 EXECUTE=00100 MEMORY=01000 WRITEBACK=10000
opcode_reg  out  7  latched instr[6:0]
AluControl_reg  out  4  latched ALU operation code
PCSrc_reg  out  1  1 = PC target from ALU (branch/jump), 0 = PC+4
ir_write  out  1  instruction register load strobe
pc_write  out  1  PC update strobe
mem_req  out  1  memory access request
mem_we  out  1  store write enable (qualifies mem_req)
reg_write  out  1  register file write strobe
illegal  out  1  one-cycle pulse on unsupported opcode
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (sampled high at clk edge): next cycle current_stage=00001, opcode_reg=0, AluControl_reg=0000, PCSrc_reg=0, instret=0, all strobes 0. Reset mid-instruction aborts it with no strobes and no instret increment.
- current_stage is the state register. Strobes are Moore/Mealy decodes of state plus latched fields. opcode_reg/AluControl_reg/PCSrc_reg load on the DECODE->EXECUTE edge and hold until the next DECODE exit.
- FETCH: mem_req=1, mem_we=0. While mem_ready=0, stay in FETCH. When mem_ready=1: ir_write=1, pc_write=1 (PC+4), latch instr, go to DECODE.
- DECODE: one cycle. Legal opcode goes to EXECUTE. Otherwise illegal=1 and the next stage is FETCH.
- EXECUTE: one cycle. Next stage by opcode:
  - 0110011 R, 0010011 I-ALU, 0110111 LUI, 0010111 AUIPC: go to WRITEBACK.
  - 0000011 LOAD, 0100011 STORE: go to MEMORY.
  - 1100011 BRANCH: pc_write=Cond_Chk_reg. Go to FETCH and retire.
  - 1101111 JAL, 1100111 JALR: pc_write=1. Go to WRITEBACK.
- MEMORY: mem_req=1, mem_we=1 for STORE only. Hold until mem_ready=1. LOAD then goes to WRITEBACK. STORE goes to FETCH and retires.
- WRITEBACK: reg_write=1 for one cycle, retire, go to FETCH.
- Retire: instret increments by 1 on the exit edge. It wraps all-ones -> 0. Illegal instructions do not retire.
- PCSrc_reg=1 for BRANCH/JAL/JALR, otherwise 0.
- AluControl_reg codes:
  - 0000 ADD: loads, stores, LUI, AUIPC, JAL, JALR, and ADD/ADDI.
  - ALU ops: 0001 SUB (R only, funct7[5]=1), 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA (funct7[5]=1), 1110 OR, 1111 AND.
  - Branches by funct3: 1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE, 1100 BLTU, 1101 BGEU.
  - Undefined branch funct3 (010/011) is illegal.
- mem_ready is ignored outside FETCH/MEMORY.

Optional Feature:
ILLEGAL_HALT_EN
- Defined: an illegal opcode pulses illegal, then the unit enters HALT (current_stage=00000) with all strobes 0 until reset.
- Undefined: pulse illegal and return to FETCH; the PC is already advanced, so the instruction is skipped.

Decomposition:
- Package rv32i_ctrl_pkg: opcode constants, one-hot stage constants, AluControl code constants.
- Sub-module rv32i_alu_ctrl_dec: combinational {opcode, funct3, funct7[5]} -> AluControl, PCSrc, legal.
- The FSM and counter stay in the top module.

Test Plan:
1. Assert reset 2 cycles, then deassert -> current_stage=00001, mem_req=1, all other strobes 0, instret=0.
2. instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> stages 00001,00010,00100,10000; opcode_reg=0110011, AluControl_reg=0000, PCSrc_reg=0; reg_write only in WRITEBACK; instret=1. Same with 0x402081B3 -> AluControl_reg=0001.
3. instr=0x00108463 (beq x1,x1,+8), Cond_Chk_reg=1 in EXECUTE -> AluControl_reg=1000, PCSrc_reg=1, pc_write in EXECUTE, FETCH after 3 cycles. Repeat with Cond_Chk_reg=0 -> no EXECUTE pc_write; instret still increments.
4. instr=0x0040A283 (lw x5,4(x1)), mem_ready low 3 cycles in MEMORY -> stays 01000 with mem_req=1, mem_we=0; then WRITEBACK with reg_write=1. Store 0x0050A223 -> mem_we=1 in MEMORY, no reg_write.
5. instr=0xFFFFFFFF -> illegal pulse in DECODE, instret unchanged; without macro, back to 00001; with ILLEGAL_HALT_EN, current_stage=00000 until reset.
6. Reset asserted while in MEMORY -> next cycle 00001, no reg_write, instret unchanged. Preload instret to all-ones and retire one instruction -> 0.
